// File: rtl/traffic_phase_sequencer.sv
// Single-approach traffic-light sequencer: RED -> GREEN -> YELLOW countdown with a
// flashing-yellow night override, driving the countdown/colour-select pair for the display.
module traffic_phase_sequencer #(
   parameter int TICK_DIV    = 1000,
   parameter int RED_TIME    = 30,
   parameter int GREEN_TIME  = 25,
   parameter int YELLOW_TIME = 5
) (
   input  logic       clock1KHz,
   input  logic       rst,
   input  logic       hold,
   input  logic       night,
   output logic [7:0] NUM,
   output logic       R,
   output logic       lamp_red,
   output logic       lamp_yellow,
   output logic       lamp_green,
   output logic       tick_1hz
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {RED, GREEN, YELLOW, FLASH} state_t;

   state_t          state_q;
   logic [PW-1:0]   presc_q, presc_d;
   logic            tick_q, tick_d;
   logic [7:0]      num_q;
   logic            r_q, red_q, yellow_q, green_q;

   // Prescaler stalls in place under hold so a release resumes the partial second.
   always_comb begin
      presc_d = presc_q;
      tick_d  = 1'b0;
      if (!hold) begin
         if (presc_q == PW'(TICK_DIV - 1)) begin
            presc_d = '0;
            tick_d  = 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock1KHz or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
      end
   end

   // Phase FSM reacts to the registered tick; night preempts both hold and the tick.
   always_ff @(posedge clock1KHz or posedge rst) begin
      if (rst) begin
         state_q  <= RED;
         num_q    <= 8'(RED_TIME);
         r_q      <= 1'b1;
         red_q    <= 1'b1;
         yellow_q <= 1'b0;
         green_q  <= 1'b0;
      end else if (night && state_q != FLASH) begin
         state_q  <= FLASH;
         num_q    <= 8'd0;
         r_q      <= 1'b0;
         red_q    <= 1'b0;
         yellow_q <= 1'b0;
         green_q  <= 1'b0;
      end else if (!hold && tick_q) begin
         unique case (state_q)
            RED: begin
               if (num_q == 8'd1) begin
                  state_q <= GREEN;
                  num_q   <= 8'(GREEN_TIME);
                  r_q     <= 1'b0;
                  red_q   <= 1'b0;
                  green_q <= 1'b1;
               end else begin
                  num_q <= num_q - 8'd1;
               end
            end
            GREEN: begin
               if (num_q == 8'd1) begin
                  state_q  <= YELLOW;
                  num_q    <= 8'(YELLOW_TIME);
                  green_q  <= 1'b0;
                  yellow_q <= 1'b1;
               end else begin
                  num_q <= num_q - 8'd1;
               end
            end
            YELLOW: begin
               if (num_q == 8'd1) begin
                  state_q  <= RED;
                  num_q    <= 8'(RED_TIME);
                  r_q      <= 1'b1;
                  yellow_q <= 1'b0;
                  red_q    <= 1'b1;
               end else begin
                  num_q <= num_q - 8'd1;
               end
            end
            FLASH: begin
               if (!night) begin
                  state_q  <= RED;
                  num_q    <= 8'(RED_TIME);
                  r_q      <= 1'b1;
                  red_q    <= 1'b1;
                  yellow_q <= 1'b0;
               end else begin
                  yellow_q <= ~yellow_q;
               end
            end
         endcase
      end
   end

   assign NUM         = num_q;
   assign R           = r_q;
   assign lamp_red    = red_q;
   assign lamp_yellow = yellow_q;
   assign lamp_green  = green_q;
   assign tick_1hz    = tick_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with a 4-cycle tick and 3/2/1 s phases.
// Edge numbers below count rising edges since reset release; samples are taken on falling edges.
module tb_traffic_phase_sequencer;

   logic       clk = 1'b0;
   logic       rst, hold, night;
   logic [7:0] NUM;
   logic       R, lamp_red, lamp_yellow, lamp_green, tick_1hz;

   int tests = 0;
   int fails = 0;
   int ecount = 0;

   traffic_phase_sequencer #(
      .TICK_DIV(4), .RED_TIME(3), .GREEN_TIME(2), .YELLOW_TIME(1)
   ) dut (
      .clock1KHz(clk), .rst(rst), .hold(hold), .night(night),
      .NUM(NUM), .R(R), .lamp_red(lamp_red), .lamp_yellow(lamp_yellow),
      .lamp_green(lamp_green), .tick_1hz(tick_1hz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s @E%0d: observed %0d expected %0d", tag, ecount, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] n, input logic r,
                          input logic rd, input logic ye, input logic gr);
      chk({tag, ".NUM"}, NUM, n);
      chk({tag, ".R"}, {7'd0, R}, {7'd0, r});
      chk({tag, ".red"}, {7'd0, lamp_red}, {7'd0, rd});
      chk({tag, ".yellow"}, {7'd0, lamp_yellow}, {7'd0, ye});
      chk({tag, ".green"}, {7'd0, lamp_green}, {7'd0, gr});
      $display("[TB] E%0d %s NUM=%0d R=%0d lamps(r,y,g)=%0d%0d%0d tick=%0d",
               ecount, tag, NUM, R, lamp_red, lamp_yellow, lamp_green, tick_1hz);
   endtask

   task automatic run_to(input int e);
      while (ecount < e) begin
         @(negedge clk);
         ecount++;
      end
   endtask

   initial begin
      rst = 1'b1; hold = 1'b0; night = 1'b0;
      @(negedge clk);
      chk_all("reset", 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("reset.tick", {7'd0, tick_1hz}, 8'd0);
      rst = 1'b0;

      // Full cycle: ticks after E4k, NUM updates on E4k+1.
      for (int k = 1; k <= 25; k++) begin
         run_to(k);
         chk("cycle.tick", {7'd0, tick_1hz}, {7'd0, (k % 4 == 0)});
         case (k)
            4:  chk_all("red3",    8'd3, 1'b1, 1'b1, 1'b0, 1'b0);
            5:  chk_all("red2",    8'd2, 1'b1, 1'b1, 1'b0, 1'b0);
            9:  chk_all("red1",    8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
            13: chk_all("green2",  8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
            17: chk_all("green1",  8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
            21: chk_all("yellow1", 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
            25: chk_all("red3b",   8'd3, 1'b1, 1'b1, 1'b0, 1'b0);
            default: ;
         endcase
      end

      // Hold for 10 cycles at NUM=2 with prescaler at 2.
      run_to(30);
      chk("hold.pre", NUM, 8'd2);
      hold = 1'b1;
      for (int k = 31; k <= 40; k++) begin
         run_to(k);
         chk("hold.tick", {7'd0, tick_1hz}, 8'd0);
      end
      chk_all("hold.end", 8'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      hold = 1'b0;
      run_to(41);
      chk("resume.tick41", {7'd0, tick_1hz}, 8'd0);
      run_to(42);
      chk("resume.tick42", {7'd0, tick_1hz}, 8'd1);
      run_to(43);
      chk_all("resume.red1", 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);

      // Night during GREEN NUM=2.
      run_to(47);
      chk_all("n.green2", 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
      night = 1'b1;
      run_to(48);
      chk_all("n.flash", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_to(50);
      chk("n.tick50", {7'd0, tick_1hz}, 8'd1);
      chk("n.y50", {7'd0, lamp_yellow}, 8'd0);
      run_to(51);
      chk_all("n.y51", 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_to(55);
      chk_all("n.y55", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_to(59);
      chk_all("n.y59", 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Night drop mid-period: FLASH persists until the tick at E62.
      run_to(60);
      night = 1'b0;
      run_to(61);
      chk_all("x.e61", 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_to(62);
      chk("x.tick62", {7'd0, tick_1hz}, 8'd1);
      chk_all("x.e62", 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_to(63);
      chk_all("x.red3", 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);

      // Night rising with the tick at RED NUM=1.
      run_to(74);
      chk("c.tick74", {7'd0, tick_1hz}, 8'd1);
      chk_all("c.red1", 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      night = 1'b1;
      run_to(75);
      chk_all("c.flash", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      night = 1'b0;
      for (int k = 76; k <= 78; k++) begin
         run_to(k);
         chk("c.num", NUM, 8'd0);
         chk("c.green", {7'd0, lamp_green}, 8'd0);
      end
      run_to(79);
      chk_all("c.red3", 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset during YELLOW with prescaler at 2.
      run_to(100);
      chk_all("r.yellow", 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1 chk_all("r.async", 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      #1 rst = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("r.tick", {7'd0, tick_1hz}, {7'd0, (k == 4)});
      end
      chk_all("r.red3", 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
- Upstream producer of the countdown interface consumed by the two-colour 7-segment display block.
- Runs the single-approach traffic-light cycle RED -> GREEN -> YELLOW -> RED.
- Outputs the seconds remaining in the current phase (NUM) and the display-select flag R.
- Drives the three lamp outputs and provides a night-mode flashing-yellow override.
- Clocked from the 1 kHz system clock; derives its own 1 s tick.

Parameters:
- TICK_DIV, 1000: clock cycles per 1 s tick; legal range 2..65535.
- RED_TIME, 30: red phase length in seconds; legal range 1..99.
- GREEN_TIME, 25: green phase length in seconds; legal range 1..99.
- YELLOW_TIME, 5: yellow phase length in seconds; legal range 1..99.

Ports:
- clock1KHz  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- hold  input  1  freezes prescaler and countdown while high; state and outputs are held.
- night  input  1  night mode request (flashing yellow).
- NUM  output  8  seconds remaining in the current phase, binary, 0..99.
- R  output  1  1 = show NUM on red digits; 0 = show on green digits.
- lamp_red  output  1  red lamp on.
- lamp_yellow  output  1  yellow lamp on.
- lamp_green  output  1  green lamp on.
- tick_1hz  output  1  one-cycle pulse at each 1 s boundary.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=RED, NUM=RED_TIME, R=1, lamp_red=1, other lamps 0.
  - prescaler=0, tick_1hz=0, flash toggle=0.
  - All outputs are registered.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick_1hz=1 in the cycle after the count reaches TICK_DIV-1 (registered pulse, exactly one cycle wide).
  - hold=1 stops the count and suppresses tick. Releasing hold resumes from the held count; there is no restart.
- States: RED, GREEN, YELLOW, FLASH.
- Countdown, on each tick in RED/GREEN/YELLOW:
  - If NUM>1: NUM<=NUM-1.
  - If NUM==1: advance to the next phase and load that phase's duration into NUM in the same cycle.
  - Each displayed value is therefore held exactly one tick period: a phase shows DURATION..1, and 0 never appears.
- Phase-to-output mapping:
  - RED: R=1, lamp_red=1.
  - GREEN: R=0, lamp_green=1.
  - YELLOW: R=0 (countdown shown on the green digits), lamp_yellow=1.
  - Exactly one lamp is on in these three states.
- Night mode:
  - night sampled high in any non-FLASH state -> next cycle FLASH, NUM=0, R=0, all lamps 0, flash toggle=0.
  - This happens immediately, not tick-aligned.
  - In FLASH, each tick toggles lamp_yellow; red and green stay 0.
- Night exit:
  - night low in FLASH -> stay in FLASH until the next tick.
  - On that tick, enter RED with NUM=RED_TIME and R=1; lamp_yellow=0.
- Priorities:
  - rst > night > hold > tick.
  - night rising in the same cycle as a tick: FLASH wins, and the countdown step is discarded.
  - hold=1 while in FLASH freezes the flashing as well.
- Width rules:
  - NUM is 8 bits; durations are ≤99, so there is no overflow.
  - The decrement never underflows because NUM==1 triggers a reload.
- Reset mid-phase: immediate return to the reset values, with the prescaler cleared.
- Timing relative to the display: NUM and R change only on rising edges. The display samples on the falling edge, so values are stable when sampled.

Test Plan:
1. TICK_DIV=4, RED=3, GREEN=2, YELLOW=1; release reset -> NUM/R/lamps sequence:
   - 3,2,1 with R=1 and red on;
   - 2,1 with R=0 and green on;
   - 1 with R=0 and yellow on;
   - back to 3 with R=1;
   - tick_1hz pulses every 4th cycle.
2. Assert hold for 10 cycles mid-RED at NUM=2 -> NUM stays 2, no tick_1hz. After release, the next tick arrives after the remaining prescaler cycles, not after 4 new cycles.
3. Assert night during GREEN (NUM=2) -> next cycle NUM=0, R=0, all lamps 0. lamp_yellow then toggles 1,0,1 on successive ticks.
4. Drop night in FLASH mid-period -> FLASH persists until the next tick, then NUM=3, R=1, lamp_red=1, lamp_yellow=0.
5. Raise night in the exact cycle tick_1hz fires in RED with NUM=1 -> FLASH entered; no GREEN state and no NUM=2 appear.
6. Pulse rst during YELLOW with the prescaler at 2 -> asynchronous return to NUM=3, R=1, lamp_red=1. The first tick then comes 4 cycles after rst deasserts.
